// File: rtl/cfg_pkg.sv
// Shared configuration for the Si5340 I2C register responder.
package cfg_pkg;

  // 7-bit device address answered by default.
  localparam logic [6:0]  SLAVE_ADDR = 7'h74;
  localparam int unsigned DATA_WIDTH = 8;

  // R/W bit of the address byte.
  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } r_w_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into clk_i and derives SCL edges plus START/STOP.
module i2c_line_sync (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  // Two-flop synchronisers plus one delayed copy for edge detection; idle bus is high.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SDA move next to an SCL edge is not misread.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/si5340_i2c_responder.sv
// I2C target exposing a byte register file behind a 16-bit auto-incrementing pointer.
module si5340_i2c_responder #(
  parameter logic [6:0]  SLAVE_ADDR = cfg_pkg::SLAVE_ADDR,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen_o,
  output logic        wr_stb_o,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned DW = cfg_pkg::DATA_WIDTH;

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StRegHi, StAckHi, StRegLo, StAckLo,
    StWrData, StAckWr, StRdData, StRdAck
  } state_t;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic          byte_done_q;  // 8th bit seen (or RD_ACK sampled), waiting for SCL fall
  logic [DW-1:0] shreg_q;
  logic [DW-1:0] tx_q;
  logic [DW-1:0] hi_q;
  logic [15:0]   ptr_q;
  cfg_pkg::r_w_t rw_q;
  logic          oen_q;
  logic          wr_stb_q;
  logic [DW-1:0] wdata_q;
  logic          busy_q;

  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic [DW-1:0] rd_byte;

  assign rd_byte = mem_q[ptr_q[AW-1:0]];

  // Register file: no reset so contents survive arstn_i; written the cycle after the strobe.
  always_ff @(posedge clk_i) begin
    if (wr_stb_q) begin
      mem_q[ptr_q[AW-1:0]] <= wdata_q;
    end
  end

  // Protocol FSM; all outputs registered, SDA only changes after a synchronised SCL fall.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shreg_q     <= '0;
      tx_q        <= '0;
      hi_q        <= '0;
      ptr_q       <= 16'h0000;
      rw_q        <= cfg_pkg::WRITE;
      oen_q       <= 1'b1;
      wr_stb_q    <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      // Increment after the strobe cycle so reg_addr_o shows the written address with it.
      if (wr_stb_q) begin
        ptr_q <= ptr_q + 16'd1;
      end
      if (stop_det) begin
        state_q     <= StIdle;
        oen_q       <= 1'b1;
        busy_q      <= 1'b0;
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
      end else if (start_det) begin
        state_q     <= StDevAddr;
        oen_q       <= 1'b1;
        bit_cnt_q   <= 3'd0;
        byte_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StDevAddr, StRegHi, StRegLo, StWrData: begin
            if (scl_rise && !byte_done_q) begin
              shreg_q   <= {shreg_q[DW-2:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_done_q <= 1'b1;
              end
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              bit_cnt_q   <= 3'd0;
              case (state_q)
                StDevAddr: begin
                  if (shreg_q[7:1] == SLAVE_ADDR) begin
                    state_q <= StAckDev;
                    oen_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    rw_q    <= cfg_pkg::r_w_t'(shreg_q[0]);
                  end else begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                  end
                end
                StRegHi: begin
                  hi_q    <= shreg_q;
                  state_q <= StAckHi;
                  oen_q   <= 1'b0;
                end
                StRegLo: begin
                  ptr_q   <= {hi_q, shreg_q};
                  state_q <= StAckLo;
                  oen_q   <= 1'b0;
                end
                default: begin
                  wr_stb_q <= 1'b1;
                  wdata_q  <= shreg_q;
                  state_q  <= StAckWr;
                  oen_q    <= 1'b0;
                end
              endcase
            end
          end
          StAckDev, StAckHi, StAckLo, StAckWr: begin
            if (scl_fall) begin
              oen_q <= 1'b1;
              case (state_q)
                StAckDev: begin
                  if (rw_q == cfg_pkg::READ) begin
                    state_q <= StRdData;
                    tx_q    <= rd_byte;
                    oen_q   <= rd_byte[DW-1];
                  end else begin
                    state_q <= StRegHi;
                  end
                end
                StAckHi: state_q <= StRegLo;
                default: state_q <= StWrData;
              endcase
            end
          end
          StRdData: begin
            if (scl_rise && !byte_done_q) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_done_q <= 1'b1;
              end
            end else if (scl_fall) begin
              if (byte_done_q) begin
                byte_done_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
                oen_q       <= 1'b1;
                state_q     <= StRdAck;
              end else begin
                tx_q  <= {tx_q[DW-2:0], 1'b0};
                oen_q <= tx_q[DW-2];
              end
            end
          end
          StRdAck: begin
            if (scl_rise && !byte_done_q) begin
              ptr_q <= ptr_q + 16'd1;
              if (sda_s) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                byte_done_q <= 1'b1;
              end
            end else if (scl_fall && byte_done_q) begin
              // Pointer was advanced at the ACK sample, so rd_byte is already the next byte.
              byte_done_q <= 1'b0;
              state_q     <= StRdData;
              tx_q        <= rd_byte;
              oen_q       <= rd_byte[DW-1];
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_o       = 1'b0;
  assign sda_oen_o   = oen_q;
  assign wr_stb_o    = wr_stb_q;
  assign reg_addr_o  = ptr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_si5340_i2c_responder.sv
// Self-checking bench: bit-banged I2C master, transaction-level register model, per-cycle monitor.
module tb_si5340_i2c_responder;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_o, sda_oen_o, wr_stb_o, busy_o;
  logic [15:0] reg_addr_o;
  logic [7:0]  reg_wdata_o;

  int n_checks = 0;
  int n_err    = 0;

  // Model: memory image, pointer, and the write strobes still owed by the DUT.
  logic [7:0]  mem_m [256];
  logic [15:0] ptr_m = 16'h0000;
  logic [23:0] exp_q [$];
  logic        drive_ok = 1'b0;
  logic        run = 1'b0;

  assign sda_bus = m_sda & (sda_oen_o ? 1'b1 : sda_o);

  si5340_i2c_responder dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_oen_o   (sda_oen_o),
    .wr_stb_o    (wr_stb_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: SDA only pulled when the protocol allows it; each strobe matches the model.
  always @(negedge clk) begin
    if (run && arstn) begin
      n_checks++;
      if (sda_o !== 1'b0 || sda_oen_o === 1'bx || (sda_oen_o === 1'b0 && !drive_ok)) begin
        n_err++;
        $display("FAIL sda_drive at %0t: oen=%b sda_o=%b allowed=%b", $time, sda_oen_o, sda_o,
                 drive_ok);
      end
      if (wr_stb_o !== 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_stb_unexpected: got addr=%h data=%h, expected no strobe",
                   reg_addr_o, reg_wdata_o);
        end else if ({reg_addr_o, reg_wdata_o} !== exp_q[0]) begin
          n_err++;
          $display("FAIL wr_stb: got %h, expected %h", {reg_addr_o, reg_wdata_o}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; #100; scl = 1'b1; #100; s = sda_bus; #100; scl = 1'b0; #100;
  endtask

  task automatic start_c();
    if (scl == 1'b0) begin
      m_sda = 1'b1; #100; scl = 1'b1; #100;
    end
    m_sda = 1'b0; #100; scl = 1'b0; #100;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #100; scl = 1'b1; #100; m_sda = 1'b1; #200;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic then_read,
                           output logic ack);
    logic s;
    for (int i = 7; i > 0; i--) clock_bit(b[i], s);
    m_sda = b[0]; #100; scl = 1'b1; #200; scl = 1'b0;
    drive_ok = exp_ack; #100;
    clock_bit(1'b1, s);
    ack = ~s;
    drive_ok = then_read;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    drive_ok = 1'b0;
    m_sda = ~mack; #100; scl = 1'b1; #200; scl = 1'b0;
    drive_ok = mack; #100;
  endtask

  task automatic model_write(input logic [7:0] b);
    exp_q.push_back({ptr_m, b});
    mem_m[ptr_m[7:0]] = b;
    ptr_m = ptr_m + 16'd1;
  endtask

  task automatic addr_phase(input logic [15:0] addr);
    logic ack;
    send_byte(8'hE8, 1'b1, 1'b0, ack); chk("dev_ack_w", ack, 1);
    chk("busy_on", busy_o, 1);
    send_byte(addr[15:8], 1'b1, 1'b0, ack); chk("hi_ack", ack, 1);
    send_byte(addr[7:0], 1'b1, 1'b0, ack); chk("lo_ack", ack, 1);
    ptr_m = addr;
  endtask

  task automatic wr_txn(input logic [15:0] addr, input int n, input logic [7:0] d0,
                        input logic [7:0] d1);
    logic ack;
    start_c();
    addr_phase(addr);
    for (int k = 0; k < n; k++) begin
      model_write(k == 0 ? d0 : d1);
      send_byte(k == 0 ? d0 : d1, 1'b1, 1'b0, ack); chk("data_ack", ack, 1);
    end
    stop_c();
    chk("busy_off", busy_o, 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] r0, r1, e;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    // Reset values
    #23;
    chk("rst_oen", sda_oen_o, 1);
    chk("rst_stb", wr_stb_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", reg_addr_o, 16'h0000);
    chk("rst_wdata", reg_wdata_o, 8'h00);
    chk("rst_sda_o", sda_o, 0);
    @(negedge clk); #3;
    arstn = 1'b1;
    run = 1'b1;
    #400;

    // Prime the neighbouring register read back later
    wr_txn(16'h0B25, 1, 8'h5A, 8'h00);

    // Single-byte write
    wr_txn(16'h0B24, 1, 8'hC0, 8'h00);
    chk("w1_addr_after", reg_addr_o, 16'h0B25);
    chk("w1_wdata", reg_wdata_o, 8'hC0);

    // Pointer set, repeated START, two-byte read ACK then NACK
    start_c();
    addr_phase(16'h0B24);
    start_c();
    send_byte(8'hE9, 1'b1, 1'b1, ack); chk("dev_ack_r", ack, 1);
    e = mem_m[ptr_m[7:0]]; ptr_m = ptr_m + 16'd1;
    read_byte(1'b1, r0); chk("rd0_model", r0, e); chk("rd0_lit", r0, 8'hC0);
    e = mem_m[ptr_m[7:0]]; ptr_m = ptr_m + 16'd1;
    read_byte(1'b0, r1); chk("rd1_model", r1, e); chk("rd1_lit", r1, 8'h5A);
    stop_c();
    chk("rd_ptr_model", reg_addr_o, ptr_m);
    chk("rd_ptr_lit", reg_addr_o, 16'h0B26);
    chk("rd_busy_off", busy_o, 0);

    // Foreign address 0x75: no ACK, never busy
    start_c();
    send_byte(8'hEA, 1'b0, 1'b0, ack); chk("foreign_nack", ack, 0);
    chk("foreign_busy", busy_o, 0);
    stop_c();
    chk("foreign_busy_end", busy_o, 0);

    // Pointer wrap
    wr_txn(16'hFFFF, 2, 8'h11, 8'h22);
    chk("wrap_addr_lit", reg_addr_o, 16'h0001);

    // STOP after 4 data bits discards the byte
    start_c();
    addr_phase(16'h0030);
    for (int i = 0; i < 4; i++) clock_bit(i[0], ack);
    stop_c();
    chk("abort_busy", busy_o, 0);
    chk("abort_ptr", reg_addr_o, 16'h0030);
    wr_txn(16'h0030, 1, 8'h3C, 8'h00);
    chk("after_abort_addr", reg_addr_o, 16'h0031);

    // Reset while driving a 0 read bit (mem[0] = 0x22)
    start_c();
    addr_phase(16'h0000);
    start_c();
    send_byte(8'hE9, 1'b1, 1'b1, ack); chk("dev_ack_r2", ack, 1);
    chk("rd_drive_low", sda_oen_o, 0);
    #7;
    arstn = 1'b0;
    #1;
    chk("arst_oen", sda_oen_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_addr", reg_addr_o, 16'h0000);
    drive_ok = 1'b0;
    ptr_m = 16'h0000;
    #50;
    arstn = 1'b1;
    m_sda = 1'b1; #100; scl = 1'b1; #200;
    wr_txn(16'h0010, 1, 8'h77, 8'h00);
    chk("post_rst_addr", reg_addr_o, 16'h0011);

    #500;
    chk("stb_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/si5340_i2c_responder.md
SI5340_I2C_RESPONDER -- requirements
Module: si5340_i2c_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default cfg_pkg::SLAVE_ADDR (7'h74), 7-bit device address answered.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit register bytes held; power of two.
REQ-003 SHALL have port clk_i  input  1  system clock; single clock domain; frequency at least 10x SCL.
REQ-004 SHALL have port arstn_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port scl_i  input  1  SCL line, asynchronous.
REQ-006 SHALL have port sda_i  input  1  SDA line, asynchronous.
REQ-007 SHALL have port sda_o  output  1  SDA drive value, constant 0.
REQ-008 SHALL have port sda_oen_o  output  1  SDA output enable, active low (0 pulls SDA low).
REQ-009 SHALL have port wr_stb_o  output  1  one-cycle pulse per register byte written.
REQ-010 SHALL have port reg_addr_o  output  16  register pointer; with wr_stb_o it is the written address.
REQ-011 SHALL have port reg_wdata_o  output  8  byte written; valid with wr_stb_o.
REQ-012 SHALL have port busy_o  output  1  high from addressed START until STOP or return to IDLE.

Function
REQ-013 SHALL pass scl_i/sda_i through 2-FF synchronizers; all decisions use synchronized values and their edges.
REQ-014 SHALL detect START as SDA falling while SCL high, STOP as SDA rising while SCL high.
REQ-015 SHALL sample SDA on SCL rising edge, MSB first, bit counter 0..7; SHALL change sda_oen_o only after SCL falling edge.
REQ-016 SHALL implement states IDLE, DEV_ADDR, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-017 IDLE->DEV_ADDR on START; DEV_ADDR after 8 bits: match -> ACK_DEV, mismatch -> IDLE, no ACK driven.
REQ-018 ACK state: SHALL drive sda_oen_o=0 from SCL fall after bit 8 to next SCL fall.
REQ-019 ACK_DEV with R/W=0 -> REG_HI -> ACK_HI -> REG_LO -> ACK_LO -> WR_DATA <-> ACK_WR; pointer = {hi,lo} loaded at end of REG_LO.
REQ-020 Each byte completed in WR_DATA SHALL write mem[ptr mod MEM_DEPTH], pulse wr_stb_o once with pre-increment address, then ptr += 1.
REQ-021 ACK_DEV with R/W=1 -> RD_DATA; SHALL shift out mem[ptr mod MEM_DEPTH]; releasing SDA (oen=1) for 1-bits.
REQ-022 RD_ACK: master ACK (SDA low) -> ptr += 1, next byte; master NACK -> ptr += 1, IDLE (SDA released).
REQ-023 Pointer SHALL wrap 16'hFFFF -> 16'h0000; increment in both directions.
REQ-024 Repeated START in any state SHALL go to DEV_ADDR, bit counter cleared, pointer retained.
REQ-025 STOP in any state, including mid-byte, SHALL go to IDLE, release SDA, discard partial byte, busy_o=0.
REQ-026 START and STOP are recognised even while SDA is being driven by this block (for example, partial data lost).
REQ-027 No clock stretching; SCL never driven.

Reset
REQ-028 On arstn_i low: state=IDLE, sda_oen_o=1, wr_stb_o=0, busy_o=0, reg_addr_o=0, reg_wdata_o=0, counters and synchronizers=1/idle, immediately (asynchronous).
REQ-029 Register memory contents SHALL NOT be affected by reset; initial contents all zero.
REQ-030 Reset asserted mid-transfer SHALL release SDA within the same cycle; after deassertion the block waits for a new START.

Structure
REQ-031 SLAVE_ADDR, DATA_WIDTH (8), and r_w enum (WRITE=0, READ=1) SHALL come from cfg_pkg; state enum stays local.
REQ-032 Synchronizer and START/STOP/edge detection SHALL be sub-module i2c_line_sync.

Verification
REQ-033 Write S,0xE8,0x0B,0x24,0xC0,P -> four ACKs, one wr_stb_o with reg_addr_o=0x0B24, reg_wdata_o=0xC0.
REQ-034 S,0xE8,0x0B,0x24,Sr,0xE9, read 2 bytes ACK then NACK, P -> bytes 0xC0 then mem[0x25]; pointer ends 0x0B26.
REQ-035 S,0xEA (address 0x75) -> no ACK, SDA never driven, no wr_stb_o, busy_o stays 0.
REQ-036 Write at 0xFFFF bytes 0x11,0x22 -> wr_stb_o at 0xFFFF then 0x0000.
REQ-037 STOP after 4 bits of data byte -> IDLE, no wr_stb_o, next full write succeeds.
REQ-038 arstn_i low during read while SDA held low -> sda_oen_o=1 same cycle; subsequent write transaction ACKed normally.
